ids_bus_arbiter: RTL

//  Arbitrates the shared data-side path of the IDS bus between the SPI slave, the

---
 rtl/ids_bus_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ids_bus_arbiter.sv
// IDS bus data-side arbiter: SPI slave, core DMEM port and DMA share one bus path.
// Optional macro IDS_ARB_RR_EN enables DMA/DMEM round-robin (SPI stays highest).
//
// state    | meaning
// ST_IDLE  | no owner, bus select is 00
// ST_OWN   | sel_q holds the current owner
module ids_bus_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_spi,
  input  logic       i_req_dmem,
  input  logic       i_req_dma,
  output logic       o_gnt_spi,
  output logic       o_gnt_dmem,
  output logic       o_gnt_dma,
  output logic [1:0] o_sel,
  output logic       o_busy,
  output logic       o_preempt
);

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_DMEM = 2'b01;
  localparam logic [1:0] SEL_DMA  = 2'b10;
  localparam logic [1:0] SEL_SPI  = 2'b11;

  // Counter saturates at the limit so a late-arriving waiter still sees it reached.
  localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD != 0) ? HOLD_W'(MAX_HOLD - 1) : '1;

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                preempt_q, preempt_d;
  logic [2:0]          gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                rr_dma_last;

  logic [2:0] req_vec;
  logic [2:0] own_bit;
  logic [2:0] others;
  logic       owner_req;

  // Vector order throughout: {spi, dma, dmem}
  function automatic logic [2:0] decode(input logic [1:0] sel);
    case (sel)
      SEL_SPI:  decode = 3'b100;
      SEL_DMA:  decode = 3'b010;
      SEL_DMEM: decode = 3'b001;
      default:  decode = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] pick(input logic [2:0] r, input logic dma_last);
    if (r[2])              pick = SEL_SPI;
    else if (r[1] && r[0]) pick = dma_last ? SEL_DMEM : SEL_DMA;
    else if (r[1])         pick = SEL_DMA;
    else if (r[0])         pick = SEL_DMEM;
    else                   pick = SEL_NONE;
  endfunction

  assign req_vec   = {i_req_spi, i_req_dma, i_req_dmem};
  assign own_bit   = decode(sel_q);
  assign others    = req_vec & ~own_bit;
  assign owner_req = |(req_vec & own_bit);

`ifdef IDS_ARB_RR_EN
  logic dma_last_q, dma_last_d;
  assign rr_dma_last = dma_last_q;

  always_comb begin
    dma_last_d = dma_last_q;
    if (sel_d != SEL_NONE && (state_q == ST_IDLE || sel_d != sel_q)) begin
      if (sel_d == SEL_DMA)  dma_last_d = 1'b1;
      if (sel_d == SEL_DMEM) dma_last_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) dma_last_q <= 1'b0;
    else          dma_last_q <= dma_last_d;
  end
`else
  assign rr_dma_last = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= SEL_NONE;
      hold_q    <= '0;
      preempt_q <= 1'b0;
      gnt_q     <= 3'b000;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          sel_d   = pick(req_vec, rr_dma_last);
          state_d = ST_OWN;
          hold_d  = '0;
        end
      end
      ST_OWN: begin
        if (!owner_req) begin
          // Release wins over preemption, so no preempt pulse here.
          hold_d = '0;
          if (|others) begin
            sel_d = pick(others, rr_dma_last);
          end else begin
            sel_d   = SEL_NONE;
            state_d = ST_IDLE;
          end
        end else if (MAX_HOLD != 0 && hold_q >= HOLD_SAT && (|others)) begin
          sel_d     = pick(others, rr_dma_last);
          preempt_d = 1'b1;
          hold_d    = '0;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = SEL_NONE;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    gnt_d  = decode(sel_d);
    busy_d = (sel_d != SEL_NONE);
  end

  assign o_gnt_spi  = gnt_q[2];
  assign o_gnt_dma  = gnt_q[1];
  assign o_gnt_dmem = gnt_q[0];
  assign o_sel      = sel_q;
  assign o_busy     = busy_q;
  assign o_preempt  = preempt_q;

endmodule
